// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller, CSR file and writeback:
// ESTAT.IS bit positions, TCFG field positions and the injection FSM encoding.
package int_ctrl_pkg;

  localparam int unsigned IS_W      = 13;
  localparam int unsigned IS_SWI0   = 0;
  localparam int unsigned IS_SWI1   = 1;
  localparam int unsigned IS_HWI0   = 2;
  localparam int unsigned IS_HWI7   = 9;
  localparam int unsigned IS_RSVD   = 10;
  localparam int unsigned IS_TI     = 11;
  localparam int unsigned IS_IPI    = 12;

  localparam int unsigned TCFG_EN          = 0;
  localparam int unsigned TCFG_PERIODIC    = 1;
  localparam int unsigned TCFG_INITVAL_LSB = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPend = 2'd1,
    StWait = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_timer.sv
// Constant timer: TCFG/TVAL registers and the armed flag; pulses ti_set_o on expiry.
module int_timer
  import int_ctrl_pkg::*;
#(
  parameter int unsigned TimerW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tcfg_we_i,
  input  logic [TimerW-1:0] tcfg_wdata_i,
  output logic [TimerW-1:0] tcfg_o,
  output logic [TimerW-1:0] tval_o,
  output logic              ti_set_o
);

  localparam logic [TimerW-1:0] One = TimerW'(1);

  logic [TimerW-1:0] tcfg_q, tcfg_d;
  logic [TimerW-1:0] tval_q, tval_d;
  logic              armed_q, armed_d;

  always_comb begin
    tcfg_d   = tcfg_q;
    tval_d   = tval_q;
    armed_d  = armed_q;
    ti_set_o = 1'b0;
    if (tcfg_we_i) begin
      tcfg_d  = tcfg_wdata_i;
      tval_d  = {tcfg_wdata_i[TimerW-1:TCFG_INITVAL_LSB], 2'b00};
      armed_d = tcfg_wdata_i[TCFG_EN];
    end else if (armed_q) begin
      if (tval_q != '0) begin
        tval_d = tval_q - One;
      end else begin
        ti_set_o = 1'b1;
        if (tcfg_q[TCFG_PERIODIC]) begin
          tval_d = {tcfg_q[TimerW-1:TCFG_INITVAL_LSB], 2'b00};
        end else begin
          // One-shot: park at all ones so software sees a frozen counter.
          armed_d = 1'b0;
          tval_d  = '1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q  <= '0;
      tval_q  <= '1;
      armed_q <= 1'b0;
    end else begin
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      armed_q <= armed_d;
    end
  end

  assign tcfg_o = tcfg_q;
  assign tval_o = tval_q;

  // The enable bit is only consumed at write time via armed.
  logic unused_tcfg_en;
  assign unused_tcfg_en = tcfg_q[TCFG_EN];

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: ESTAT.IS, masking and one-shot injection toward decode.
// Timer and TI are included only when INT_CTRL_TIMER_EN is defined.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         hard_int_in,
  input  logic               ipi_int_in,
  input  logic               crmd_ie,
  input  logic [IS_W-1:0]    ecfg_lie,
  input  logic               swi_we,
  input  logic [1:0]         swi_wdata,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] tcfg_wdata,
  input  logic               ticlr_we,
  input  logic               int_ack,
  input  logic               excp_flush,
  input  logic               ertn_flush,
  output logic               has_int,
  output logic [IS_W-1:0]    estat_is,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval
);

  logic [IS_W-1:0] is_q, is_d;
  logic            ti_d;
  int_state_e      state_q, state_d;
  logic            pending;

`ifdef INT_CTRL_TIMER_EN
  logic ti_set;

  int_timer #(
    .TimerW (TIMER_W)
  ) u_int_timer (
    .clk          (clk),
    .reset        (reset),
    .tcfg_we_i    (tcfg_we),
    .tcfg_wdata_i (tcfg_wdata),
    .tcfg_o       (tcfg),
    .tval_o       (tval),
    .ti_set_o     (ti_set)
  );

  // Expiry beats a simultaneous clear so no tick is lost.
  assign ti_d = ti_set | (is_q[IS_TI] & ~ticlr_we);
`else
  assign tcfg = '0;
  assign tval = '0;
  assign ti_d = 1'b0;

  logic unused_timer;
  assign unused_timer = ^{tcfg_we, tcfg_wdata, ticlr_we};
`endif

  always_comb begin
    is_d                   = is_q;
    is_d[IS_SWI1:IS_SWI0]  = swi_we ? swi_wdata : is_q[IS_SWI1:IS_SWI0];
    is_d[IS_HWI7:IS_HWI0]  = hard_int_in;
    is_d[IS_RSVD]          = 1'b0;
    is_d[IS_TI]            = ti_d;
    is_d[IS_IPI]           = ipi_int_in;
  end

  assign pending = crmd_ie & (|(is_q & ecfg_lie));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (pending) state_d = StPend;
      StPend: begin
        if (int_ack)       state_d = StWait;
        else if (!pending) state_d = StIdle;
      end
      // Hold off re-injection until the tagged instruction retires through a flush.
      StWait: if (excp_flush | ertn_flush) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_q    <= '0;
      state_q <= StIdle;
    end else begin
      is_q    <= is_d;
      state_q <= state_d;
    end
  end

  assign has_int  = (state_q == StPend);
  assign estat_is = is_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: reference model compared every cycle plus directed literals.
module tb_int_ctrl;

  localparam int TW = 32;
`ifdef INT_CTRL_TIMER_EN
  localparam logic [TW-1:0] TVAL_RST = 32'hFFFF_FFFF;
`else
  localparam logic [TW-1:0] TVAL_RST = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    hard_int_in = '0;
  logic          ipi_int_in = 1'b0;
  logic          crmd_ie = 1'b0;
  logic [12:0]   ecfg_lie = '0;
  logic          swi_we = 1'b0;
  logic [1:0]    swi_wdata = '0;
  logic          tcfg_we = 1'b0;
  logic [TW-1:0] tcfg_wdata = '0;
  logic          ticlr_we = 1'b0;
  logic          int_ack = 1'b0;
  logic          excp_flush = 1'b0;
  logic          ertn_flush = 1'b0;
  logic          has_int;
  logic [12:0]   estat_is;
  logic [TW-1:0] tcfg;
  logic [TW-1:0] tval;

  int n_tests = 0;
  int n_fail  = 0;

  int_ctrl #(
    .TIMER_W (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hard_int_in (hard_int_in),
    .ipi_int_in  (ipi_int_in),
    .crmd_ie     (crmd_ie),
    .ecfg_lie    (ecfg_lie),
    .swi_we      (swi_we),
    .swi_wdata   (swi_wdata),
    .tcfg_we     (tcfg_we),
    .tcfg_wdata  (tcfg_wdata),
    .ticlr_we    (ticlr_we),
    .int_ack     (int_ack),
    .excp_flush  (excp_flush),
    .ertn_flush  (ertn_flush),
    .has_int     (has_int),
    .estat_is    (estat_is),
    .tcfg        (tcfg),
    .tval        (tval)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: interrupt bits, timer counter, and "injected"/"awaiting flush" flags.
  logic [12:0]   m_is = '0;
  logic [TW-1:0] m_tcfg = '0;
  logic [TW-1:0] m_tval = '0;
  logic          m_armed = 1'b0;
  logic          m_inj = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic          ti, expire, pend;
    logic [TW-1:0] ntcfg, ntval;
    logic          narmed, ninj, nbusy;
    if (reset) begin
      m_is <= '0; m_tcfg <= '0; m_tval <= TVAL_RST; m_armed <= 1'b0;
      m_inj <= 1'b0; m_busy <= 1'b0; m_valid <= 1'b1;
    end else begin
      ti = m_is[11]; expire = 1'b0;
      ntcfg = m_tcfg; ntval = m_tval; narmed = m_armed;
`ifdef INT_CTRL_TIMER_EN
      if (tcfg_we) begin
        ntcfg = tcfg_wdata; ntval = tcfg_wdata & ~32'd3; narmed = tcfg_wdata[0];
      end else if (m_armed) begin
        if (m_tval != 0) ntval = m_tval - 1;
        else begin
          expire = 1'b1;
          if (m_tcfg[1]) ntval = m_tcfg & ~32'd3;
          else begin narmed = 1'b0; ntval = 32'hFFFF_FFFF; end
        end
      end
      ti = expire || (ti && !ticlr_we);
`else
      ti = 1'b0;
`endif
      pend = crmd_ie && ((m_is & ecfg_lie) != 0);
      ninj = m_inj; nbusy = m_busy;
      if (m_inj) begin
        if (int_ack) begin ninj = 1'b0; nbusy = 1'b1; end
        else if (!pend) ninj = 1'b0;
      end else if (m_busy) begin
        if (excp_flush || ertn_flush) nbusy = 1'b0;
      end else if (pend) ninj = 1'b1;
      m_is <= {ipi_int_in, ti, 1'b0, hard_int_in, (swi_we ? swi_wdata : m_is[1:0])};
      m_tcfg <= ntcfg; m_tval <= ntval; m_armed <= narmed;
      m_inj <= ninj; m_busy <= nbusy;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model.has_int", {31'd0, has_int}, {31'd0, m_inj});
      check("model.estat_is", {19'd0, estat_is}, {19'd0, m_is});
      check("model.tcfg", tcfg, m_tcfg);
      check("model.tval", tval, m_tval);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    check("rst.has_int", {31'd0, has_int}, 32'd0);
    check("rst.estat_is", {19'd0, estat_is}, 32'd0);
    check("rst.tcfg", tcfg, 32'd0);
    check("rst.tval", tval, TVAL_RST);
    reset = 1'b0;

    // Hardware interrupt: 2-cycle latency, ack, flush, re-presentation.
    ecfg_lie = 13'h004; crmd_ie = 1'b1; hard_int_in = 8'h01;
    step();
    check("hwi.is", {19'd0, estat_is}, 32'h004);
    check("hwi.lat1", {31'd0, has_int}, 32'd0);
    step();  check("hwi.lat2", {31'd0, has_int}, 32'd1);
    step(); step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("hwi.ack_drop", {31'd0, has_int}, 32'd0);
    repeat (3) step();
    check("hwi.wait_hold", {31'd0, has_int}, 32'd0);
    excp_flush = 1'b1; step(); excp_flush = 1'b0;
    check("hwi.flush_edge", {31'd0, has_int}, 32'd0);
    step();  check("hwi.reassert", {31'd0, has_int}, 32'd1);
    hard_int_in = 8'h00; step();
    check("hwi.is_clr", {19'd0, estat_is}, 32'd0);
    step();  check("hwi.pend_to_idle", {31'd0, has_int}, 32'd0);

    // Enable drop in PEND, ack coincident with pending drop, ack ignored in WAIT.
    hard_int_in = 8'h01; step(); step();
    check("ie.pend", {31'd0, has_int}, 32'd1);
    crmd_ie = 1'b0; step();
    check("ie.drop", {31'd0, has_int}, 32'd0);
    crmd_ie = 1'b1; step();
    check("ie.repend", {31'd0, has_int}, 32'd1);
    int_ack = 1'b1; crmd_ie = 1'b0; step();
    check("ie.ack_wins", {31'd0, has_int}, 32'd0);
    crmd_ie = 1'b1; step();
    check("ie.wait_blocks", {31'd0, has_int}, 32'd0);
    int_ack = 1'b0; ertn_flush = 1'b1; step(); ertn_flush = 1'b0;
    step();  check("ie.ertn_reassert", {31'd0, has_int}, 32'd1);
    int_ack = 1'b1; hard_int_in = 8'h00; step(); int_ack = 1'b0;
    excp_flush = 1'b1; step(); excp_flush = 1'b0; step();

    // Software interrupt, flush ignored in PEND, reset from WAIT.
    ecfg_lie = 13'h002; swi_we = 1'b1; swi_wdata = 2'b10; step(); swi_we = 1'b0;
    check("swi.is", {19'd0, estat_is}, 32'h002);
    step();  check("swi.pend", {31'd0, has_int}, 32'd1);
    excp_flush = 1'b1; step(); excp_flush = 1'b0;
    check("swi.flush_ignored", {31'd0, has_int}, 32'd1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("swi.wait", {31'd0, has_int}, 32'd0);
    reset = 1'b1; step();
    check("rst2.has_int", {31'd0, has_int}, 32'd0);
    check("rst2.estat_is", {19'd0, estat_is}, 32'd0);
    check("rst2.tval", tval, TVAL_RST);
    reset = 1'b0;

    // IPI.
    ecfg_lie = 13'h1000; ipi_int_in = 1'b1; step();
    check("ipi.is", {19'd0, estat_is}, 32'h1000);
    step();  check("ipi.pend", {31'd0, has_int}, 32'd1);
    ipi_int_in = 1'b0; int_ack = 1'b1; step(); int_ack = 1'b0;
    excp_flush = 1'b1; step(); excp_flush = 1'b0;
    ecfg_lie = 13'h800; step();

`ifdef INT_CTRL_TIMER_EN
    // Periodic, InitVal=2: 8..0, expiry reloads 8, clear, coincident expiry/clear.
    tcfg_we = 1'b1; tcfg_wdata = 32'h0000_000B; step(); tcfg_we = 1'b0;
    check("tmr.tcfg", tcfg, 32'h0000_000B);
    check("tmr.load", tval, 32'd8);
    for (int i = 7; i >= 0; i--) begin
      step(); check("tmr.count", tval, i);
    end
    step();
    check("tmr.ti_set", {19'd0, estat_is}, 32'h800);
    check("tmr.reload", tval, 32'd8);
    ticlr_we = 1'b1; step(); ticlr_we = 1'b0;
    check("tmr.ticlr", {19'd0, estat_is}, 32'h000);
    for (int i = 6; i >= 0; i--) begin
      step(); check("tmr.count2", tval, i);
    end
    ticlr_we = 1'b1; step(); ticlr_we = 1'b0;
    check("tmr.expire_beats_clr", {19'd0, estat_is}, 32'h800);
    check("tmr.reload2", tval, 32'd8);

    // One-shot, InitVal=1; write beats expiry path, clear applies.
    tcfg_we = 1'b1; tcfg_wdata = 32'h0000_0005; ticlr_we = 1'b1; step();
    tcfg_we = 1'b0; ticlr_we = 1'b0;
    check("os.tval", tval, 32'd4);
    check("os.ti_clr", {19'd0, estat_is}, 32'h000);
    for (int i = 3; i >= 0; i--) begin
      step(); check("os.count", tval, i);
    end
    step();
    check("os.ti", {19'd0, estat_is}, 32'h800);
    check("os.frozen", tval, 32'hFFFF_FFFF);
    ticlr_we = 1'b1; step(); ticlr_we = 1'b0;
    repeat (10) step();
    check("os.no_retrig", {19'd0, estat_is}, 32'h000);
    check("os.held", tval, 32'hFFFF_FFFF);

    // Reset mid-countdown.
    tcfg_we = 1'b1; tcfg_wdata = 32'h0000_000B; step(); tcfg_we = 1'b0;
    step(); step();
    check("mid.tval", tval, 32'd6);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid.rst_tval", tval, 32'hFFFF_FFFF);
    check("mid.rst_tcfg", tcfg, 32'd0);
`else
    tcfg_we = 1'b1; tcfg_wdata = 32'h0000_0007; ticlr_we = 1'b1; step();
    tcfg_we = 1'b0; ticlr_we = 1'b0;
    check("notmr.tcfg", tcfg, 32'd0);
    check("notmr.tval", tval, 32'd0);
    repeat (10) step();
    check("notmr.ti", {19'd0, estat_is}, 32'd0);
    check("notmr.has_int", {31'd0, has_int}, 32'd0);
`endif
    ecfg_lie = '0; step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
